// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rob_pkg
// Purpose : Shared defaults and types for the ROB tag manager slice.
//           rob_tag_t  - ROB entry index (no wrap bit)
//           rob_ptr_t  - head/tail pointer including the wrap bit
//           ckpt_id_t  - branch checkpoint slot index
// Revision: 1.0 - initial release
// ============================================================================
package rob_pkg;

    localparam int ROB_WIDTH_DEF = 4;
    localparam int ALLOC_W_DEF   = 2;
    localparam int RET_W_DEF     = 2;
    localparam int NUM_CKPT_DEF  = 4;

    typedef logic [ROB_WIDTH_DEF-1:0]        rob_tag_t;
    typedef logic [ROB_WIDTH_DEF:0]          rob_ptr_t;
    typedef logic [$clog2(NUM_CKPT_DEF)-1:0] ckpt_id_t;

endpackage
`default_nettype wire

// File: rtl/rob_ckpt_pool.sv
`default_nettype none
// ============================================================================
// Module  : rob_ckpt_pool
// Purpose : Branch checkpoint pool. Holds one tail snapshot per slot, a valid
//           bit per slot and a circular allocation pointer. Handles resolve
//           (free one slot), mispredict (squash a wrap-aware range of slots
//           and rewind the pointer) and flush (free everything).
// Ports   : clk, reset          - clock, synchronous active-high reset
//           alloc_en_i/_snap_i  - claim slot at alloc pointer with snapshot
//           resolve_valid_i/_id_i - free a slot
//           mispredict_i/recovery_id_i - rewind to a slot
//           flush_i             - free all slots, pointer to 0
//           alloc_id_o          - current alloc pointer
//           slot_free_o         - slot at alloc pointer is not in use
//           recovery_snap_o     - snapshot stored at recovery_id_i
// Revision: 1.0 - initial release
// ============================================================================
module rob_ckpt_pool
    import rob_pkg::*;
#(
    parameter  int NUM_CKPT = NUM_CKPT_DEF,
    parameter  int PTR_W    = ROB_WIDTH_DEF + 1,
    localparam int CKPT_W   = $clog2(NUM_CKPT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_en_i,
    input  logic [PTR_W-1:0]  alloc_snap_i,
    input  logic              resolve_valid_i,
    input  logic [CKPT_W-1:0] resolve_id_i,
    input  logic              mispredict_i,
    input  logic [CKPT_W-1:0] recovery_id_i,
    input  logic              flush_i,
    output logic [CKPT_W-1:0] alloc_id_o,
    output logic              slot_free_o,
    output logic [PTR_W-1:0]  recovery_snap_o
);

    logic [NUM_CKPT-1:0] valid_q, valid_d;
    logic [NUM_CKPT-1:0] squash;
    logic [CKPT_W-1:0]   ptr_q, ptr_d;
    logic [CKPT_W-1:0]   span;
    logic [PTR_W-1:0]    snap_q [NUM_CKPT];

    assign alloc_id_o      = ptr_q;
    assign slot_free_o     = ~valid_q[ptr_q];
    assign recovery_snap_o = snap_q[recovery_id_i];

    // Slots from recovery_id_i up to ptr_q-1 (circular) are younger than or
    // equal to the mispredicted branch. span == 0 means the pointer has gone
    // all the way round since the recovery slot was taken, i.e. every slot
    // belongs to the squashed range.
    assign span = ptr_q - recovery_id_i;

    always_comb begin
        squash = '0;
        for (int k = 0; k < NUM_CKPT; k++) begin
            squash[k] = (span == '0) || ((CKPT_W'(k) - recovery_id_i) < span);
        end
    end

    // Resolve is applied first so that a squash or flush in the same cycle
    // overrides it; a freshly allocated slot is always a free one, so the
    // allocate write never collides with a resolve of the same slot.
    always_comb begin
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (resolve_valid_i) begin
            valid_d[resolve_id_i] = 1'b0;
        end
        if (flush_i) begin
            valid_d = '0;
            ptr_d   = '0;
        end else if (mispredict_i) begin
            valid_d = valid_d & ~squash;
            ptr_d   = recovery_id_i;
        end else if (alloc_en_i) begin
            valid_d[ptr_q] = 1'b1;
            ptr_d          = ptr_q + CKPT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    // Snapshot storage carries no reset; a slot is only read after it has
    // been written by an allocation.
    always_ff @(posedge clk) begin
        if (!reset && alloc_en_i && !flush_i && !mispredict_i) begin
            snap_q[ptr_q] <= alloc_snap_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rob_tag_manager.sv
`default_nettype none
// ============================================================================
// Module  : rob_tag_manager
// Purpose : Reorder-buffer tag allocator. Hands out up to ALLOC_W consecutive
//           ROB tags per cycle, retires up to RET_W entries from the head,
//           checkpoints the tail at each branch and restores it on mispredict.
// Ports   : clk, reset                    - clock, sync active-high reset
//           alloc_valid/_mask/_branch     - dispatch group request
//           alloc_ready/_tag/_ckpt_id     - acceptance, tags, branch ckpt slot
//           retire_cnt                    - entries retired this cycle
//           resolve_valid/resolve_ckpt_id - branch resolved, free its slot
//           mispredict/recovery_ckpt_id   - restore tail to a checkpoint
//           flush                         - drop all in-flight entries
//           head_tag, count, full, empty  - occupancy status
// Revision: 1.0 - initial release
// ============================================================================
module rob_tag_manager
    import rob_pkg::*;
#(
    parameter  int ROB_WIDTH = ROB_WIDTH_DEF,
    parameter  int ALLOC_W   = ALLOC_W_DEF,
    parameter  int RET_W     = RET_W_DEF,
    parameter  int NUM_CKPT  = NUM_CKPT_DEF,
    localparam int CKPT_W    = $clog2(NUM_CKPT),
    localparam int RCNT_W    = $clog2(RET_W + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               alloc_valid,
    input  logic [ALLOC_W-1:0]                 alloc_mask,
    input  logic [ALLOC_W-1:0]                 alloc_branch,
    output logic                               alloc_ready,
    output logic [ALLOC_W-1:0][ROB_WIDTH-1:0]  alloc_tag,
    output logic [CKPT_W-1:0]                  alloc_ckpt_id,
    input  logic [RCNT_W-1:0]                  retire_cnt,
    input  logic                               resolve_valid,
    input  logic [CKPT_W-1:0]                  resolve_ckpt_id,
    input  logic                               mispredict,
    input  logic [CKPT_W-1:0]                  recovery_ckpt_id,
    input  logic                               flush,
    output logic [ROB_WIDTH-1:0]               head_tag,
    output logic [ROB_WIDTH:0]                 count,
    output logic                               full,
    output logic                               empty
);

    localparam int DEPTH = 2 ** ROB_WIDTH;
    localparam int PTR_W = ROB_WIDTH + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    ptr_t alloc_cnt;
    ptr_t branch_snap;
    ptr_t recovery_snap;
    logic fire;
    logic ckpt_free;

    assign count    = tail_q - head_q;
    assign full     = (count == ptr_t'(DEPTH));
    assign empty    = (count == '0);
    assign head_tag = head_q[ROB_WIDTH-1:0];

    assign alloc_ready = ((ptr_t'(DEPTH) - count) >= ptr_t'(ALLOC_W))
                         && ckpt_free && !mispredict && !flush;
    assign fire        = alloc_valid && alloc_ready;

    for (genvar i = 0; i < ALLOC_W; i++) begin : g_tag
        ptr_t lane_ptr;
        assign lane_ptr     = tail_q + ptr_t'(i);
        assign alloc_tag[i] = lane_ptr[ROB_WIDTH-1:0];
    end

    always_comb begin
        alloc_cnt = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_mask[i]) begin
                alloc_cnt = alloc_cnt + ptr_t'(1);
            end
        end
    end

    // Snapshot points just past the branch, so recovery keeps the branch
    // itself and everything older.
    always_comb begin
        branch_snap = tail_q + ptr_t'(1);
        for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_branch[i]) begin
                branch_snap = tail_q + ptr_t'(i + 1);
            end
        end
    end

    rob_ckpt_pool #(
        .NUM_CKPT (NUM_CKPT),
        .PTR_W    (PTR_W)
    ) u_ckpt_pool (
        .clk             (clk),
        .reset           (reset),
        .alloc_en_i      (fire && (|alloc_branch)),
        .alloc_snap_i    (branch_snap),
        .resolve_valid_i (resolve_valid),
        .resolve_id_i    (resolve_ckpt_id),
        .mispredict_i    (mispredict),
        .recovery_id_i   (recovery_ckpt_id),
        .flush_i         (flush),
        .alloc_id_o      (alloc_ckpt_id),
        .slot_free_o     (ckpt_free),
        .recovery_snap_o (recovery_snap)
    );

    // Retirement proceeds in every cycle, including flush and mispredict.
    always_comb begin
        head_d = head_q + ptr_t'(retire_cnt);
        tail_d = tail_q;
        if (flush) begin
            tail_d = head_d;
        end else if (mispredict) begin
            tail_d = recovery_snap;
        end else if (fire) begin
            tail_d = tail_q + alloc_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    a_retire_le_count: assert property (
        @(posedge clk) disable iff (reset) ptr_t'(retire_cnt) <= count
    );

endmodule
`default_nettype wire

// File: tb/tb_rob_tag_manager.sv
`default_nettype none
// ============================================================================
// Module  : tb_rob_tag_manager
// Purpose : Directed self-checking bench for rob_tag_manager (default
//           parameters: 16 entries, 2 lanes, 2 retires, 4 checkpoints).
// Revision: 1.0 - initial release
// ============================================================================
module tb_rob_tag_manager;
    import rob_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic           alloc_valid;
    logic [1:0]     alloc_mask;
    logic [1:0]     alloc_branch;
    logic           alloc_ready;
    logic [1:0][3:0] alloc_tag;
    ckpt_id_t       alloc_ckpt_id;
    logic [1:0]     retire_cnt;
    logic           resolve_valid;
    ckpt_id_t       resolve_ckpt_id;
    logic           mispredict;
    ckpt_id_t       recovery_ckpt_id;
    logic           flush;
    rob_tag_t       head_tag;
    rob_ptr_t       count;
    logic           full;
    logic           empty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rob_tag_manager dut (
        .clk              (clk),
        .reset            (reset),
        .alloc_valid      (alloc_valid),
        .alloc_mask       (alloc_mask),
        .alloc_branch     (alloc_branch),
        .alloc_ready      (alloc_ready),
        .alloc_tag        (alloc_tag),
        .alloc_ckpt_id    (alloc_ckpt_id),
        .retire_cnt       (retire_cnt),
        .resolve_valid    (resolve_valid),
        .resolve_ckpt_id  (resolve_ckpt_id),
        .mispredict       (mispredict),
        .recovery_ckpt_id (recovery_ckpt_id),
        .flush            (flush),
        .head_tag         (head_tag),
        .count            (count),
        .full             (full),
        .empty            (empty)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid      = 1'b0;
        alloc_mask       = 2'b00;
        alloc_branch     = 2'b00;
        retire_cnt       = 2'd0;
        resolve_valid    = 1'b0;
        resolve_ckpt_id  = '0;
        mispredict       = 1'b0;
        recovery_ckpt_id = '0;
        flush            = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One dispatch group; any retire/resolve already driven rides along.
    task automatic group(input logic [1:0] m, input logic [1:0] b);
        alloc_valid  = 1'b1;
        alloc_mask   = m;
        alloc_branch = b;
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        do_reset();
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", alloc_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_tag0", alloc_tag[0], 0);
        chk("rst_tag1", alloc_tag[1], 1);
        chk("rst_ckpt", alloc_ckpt_id, 0);

        // Fill the ROB with eight two-lane groups.
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1'b1;
            alloc_mask  = 2'b11;
            #1;
            chk("fill_ready", alloc_ready, 1);
            chk("fill_tag0", alloc_tag[0], 2 * i);
            chk("fill_tag1", alloc_tag[1], 2 * i + 1);
            tick();
        end
        #1;
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_ready_low", alloc_ready, 0);
        idle();

        // Retire two from a full ROB.
        retire_cnt = 2'd2;
        tick();
        idle();
        #1;
        chk("ret_count", count, 14);
        chk("ret_full", full, 0);
        chk("ret_ready", alloc_ready, 1);
        chk("ret_tag0", alloc_tag[0], 0);
        chk("ret_tag1", alloc_tag[1], 1);
        chk("ret_head", head_tag, 2);

        // One free entry is fewer than ALLOC_W.
        group(2'b01, 2'b00);
        #1;
        chk("one_free_count", count, 15);
        chk("one_free_ready", alloc_ready, 0);

        // Branch on lane 1 at tail 5, then rewind to it.
        do_reset();
        group(2'b11, 2'b00);
        group(2'b11, 2'b00);
        group(2'b01, 2'b00);
        alloc_valid  = 1'b1;
        alloc_mask   = 2'b11;
        alloc_branch = 2'b10;
        #1;
        chk("br_ckpt", alloc_ckpt_id, 0);
        chk("br_tag0", alloc_tag[0], 5);
        chk("br_ready", alloc_ready, 1);
        tick();
        idle();
        #1;
        chk("br_ckpt_next", alloc_ckpt_id, 1);
        chk("br_count", count, 7);
        retire_cnt = 2'd2;
        group(2'b11, 2'b00);
        group(2'b11, 2'b00);
        group(2'b11, 2'b00);
        #1;
        chk("pre_mp_count", count, 11);
        mispredict = 1'b1;
        recovery_ckpt_id = 2'd0;
        #1;
        chk("mp_ready_low", alloc_ready, 0);
        tick();
        idle();
        #1;
        chk("mp_tag0", alloc_tag[0], 7);
        chk("mp_count", count, 5);
        chk("mp_head", head_tag, 2);
        chk("mp_ckpt", alloc_ckpt_id, 0);
        chk("mp_ready", alloc_ready, 1);

        // Exhaust checkpoints, then resolve slot 0.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            group(2'b01, 2'b01);
        end
        #1;
        chk("ck_full_ready", alloc_ready, 0);
        chk("ck_full_count", count, 4);
        chk("ck_full_id", alloc_ckpt_id, 0);
        resolve_valid   = 1'b1;
        resolve_ckpt_id = 2'd0;
        #1;
        chk("res_same_cycle", alloc_ready, 0);
        tick();
        idle();
        #1;
        chk("res_ready", alloc_ready, 1);

        // Mispredict to slot 2 with a competing group and a retire.
        mispredict       = 1'b1;
        recovery_ckpt_id = 2'd2;
        alloc_valid      = 1'b1;
        alloc_mask       = 2'b11;
        retire_cnt       = 2'd1;
        tick();
        idle();
        #1;
        chk("mpa_head", head_tag, 1);
        chk("mpa_count", count, 2);
        chk("mpa_tag0", alloc_tag[0], 3);
        chk("mpa_ckpt", alloc_ckpt_id, 2);
        chk("mpa_ready", alloc_ready, 1);
        // Slots 2,3 squashed and 0 resolved; slot 1 must still be held.
        group(2'b01, 2'b01);
        group(2'b01, 2'b01);
        group(2'b01, 2'b01);
        #1;
        chk("mpa_slot1_ckpt", alloc_ckpt_id, 1);
        chk("mpa_slot1_ready", alloc_ready, 0);
        chk("mpa_slot1_count", count, 5);

        // Flush at count 9 with two retiring.
        do_reset();
        group(2'b11, 2'b01);
        group(2'b11, 2'b00);
        group(2'b11, 2'b00);
        group(2'b11, 2'b00);
        group(2'b01, 2'b00);
        #1;
        chk("pre_fl_count", count, 9);
        chk("pre_fl_ckpt", alloc_ckpt_id, 1);
        flush       = 1'b1;
        retire_cnt  = 2'd2;
        alloc_valid = 1'b1;
        alloc_mask  = 2'b11;
        #1;
        chk("fl_ready_low", alloc_ready, 0);
        tick();
        idle();
        #1;
        chk("fl_empty", empty, 1);
        chk("fl_count", count, 0);
        chk("fl_head", head_tag, 2);
        chk("fl_tag0", alloc_tag[0], 2);
        chk("fl_ckpt", alloc_ckpt_id, 0);
        for (int k = 0; k < 4; k++) begin
            alloc_valid  = 1'b1;
            alloc_mask   = 2'b01;
            alloc_branch = 2'b01;
            #1;
            chk("fl_free_ready", alloc_ready, 1);
            chk("fl_free_id", alloc_ckpt_id, k);
            tick();
            idle();
        end
        #1;
        chk("fl_all_used", alloc_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rob_tag_manager.md
ROB_TAG_MANAGER -- requirements
Module: rob_tag_manager

Interface
REQ-001 The block SHALL have parameter ROB_WIDTH, default 4, meaning log2 of ROB depth (DEPTH = 2**ROB_WIDTH).
REQ-002 The block SHALL have parameter ALLOC_W, default 2, meaning allocation lanes per cycle.
REQ-003 The block SHALL have parameter RET_W, default 2, meaning maximum retirements per cycle.
REQ-004 The block SHALL have parameter NUM_CKPT, default 4 (power of two), meaning branch checkpoint slots.
REQ-005 The block SHALL have port clk, input, 1, meaning clock.
REQ-006 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 The block SHALL have port alloc_valid, input, 1, meaning dispatch group present.
REQ-008 The block SHALL have port alloc_mask, input, ALLOC_W, meaning thermometer mask of lanes needing tags (lane 0 first).
REQ-009 The block SHALL have port alloc_branch, input, ALLOC_W, meaning lane carries a branch; at most one bit set.
REQ-010 The block SHALL have port alloc_ready, output, 1, meaning group accepted this cycle if alloc_valid.
REQ-011 The block SHALL have port alloc_tag, output, ALLOC_W x ROB_WIDTH, meaning tag per lane.
REQ-012 The block SHALL have port alloc_ckpt_id, output, log2(NUM_CKPT), meaning checkpoint assigned to the branch lane.
REQ-013 The block SHALL have port retire_cnt, input, log2(RET_W+1), meaning entries retired from head this cycle.
REQ-014 The block SHALL have port resolve_valid / resolve_ckpt_id, input, 1 / log2(NUM_CKPT), meaning branch resolved correctly; free the slot.
REQ-015 The block SHALL have port mispredict / recovery_ckpt_id, input, 1 / log2(NUM_CKPT), meaning restore to that checkpoint.
REQ-016 The block SHALL have port flush, input, 1, meaning discard all in-flight entries.
REQ-017 The block SHALL have ports head_tag, count, full, empty, output, ROB_WIDTH / ROB_WIDTH+1 / 1 / 1, meaning occupancy status.

Function
REQ-018 The block SHALL keep head and tail pointers of ROB_WIDTH+1 bits (wrap bit); count = tail - head; full = (count == DEPTH); empty = (count == 0).
REQ-019 The block SHALL drive alloc_tag[i] = (tail + i) mod DEPTH, combinationally from registered tail.
REQ-020 The block SHALL assert alloc_ready iff DEPTH - count >= ALLOC_W, the next checkpoint slot is free, and mispredict and flush are low.
REQ-021 On fire (alloc_valid & alloc_ready) the block SHALL advance tail by popcount(alloc_mask) the next cycle.
REQ-022 On fire with a branch lane b, the block SHALL write the checkpoint slot at ckpt_alloc_ptr with tail + b + 1, mark it valid, and advance ckpt_alloc_ptr by 1 mod NUM_CKPT.
REQ-023 The block SHALL drive alloc_ckpt_id = ckpt_alloc_ptr, combinationally.
REQ-024 Retire SHALL advance head by retire_cnt in all non-reset cycles, including mispredict cycles; retire_cnt > count is illegal (assertion).
REQ-025 resolve_valid SHALL clear the valid bit of resolve_ckpt_id next cycle.
REQ-026 On mispredict, the block SHALL set tail to the snapshot of recovery_ckpt_id, clear valid for that slot and all slots from it up to ckpt_alloc_ptr-1 (wrap-aware), and set ckpt_alloc_ptr to recovery_ckpt_id.
REQ-027 Priority SHALL be: reset > flush > mispredict > allocate; resolve of a slot being squashed the same cycle is ignored.
REQ-028 flush SHALL set tail = head + retire_cnt and clear all checkpoint valids, returning ckpt_alloc_ptr to 0.
REQ-029 Pointer arithmetic SHALL wrap modulo 2*DEPTH with no saturation.

Reset
REQ-030 On reset the block SHALL set head, tail, count and ckpt_alloc_ptr to 0 and all checkpoint valids to 0, giving empty=1, full=0, alloc_ready=1, alloc_tag[i]=i.
REQ-031 The block SHALL NOT reset snapshot storage.
REQ-032 Reset SHALL abort any same-cycle allocate, retire, or mispredict.

Structure
REQ-033 Package rob_pkg SHALL hold the default parameters and the typedefs rob_tag_t, rob_ptr_t (wrap bit included) and ckpt_id_t.
REQ-034 The checkpoint pool (snapshots, valid bits, alloc pointer, squash-range logic) SHALL be sub-module rob_ckpt_pool.

Verification
REQ-035 A bench SHALL check: after reset, alloc_valid with mask 11 for 8 cycles -> tags 0,1 ... 14,15; full=1; alloc_ready=0.
REQ-036 A bench SHALL check: full ROB with retire_cnt=2 -> next cycle count=14, alloc_ready=1, next tags 0,1.
REQ-037 A bench SHALL check: a branch on lane 1 at tail=5 -> ckpt 0 snapshot=7; after 3 more groups, mispredict ckpt 0 -> tail=7, count=7-head, alloc_ckpt_id=0.
REQ-038 A bench SHALL check: 4 unresolved branches -> alloc_ready=0; resolve ckpt 0 -> alloc_ready=1 next cycle.
REQ-039 A bench SHALL check: mispredict with alloc_valid and retire_cnt=1 in the same cycle -> no allocation, head+1, tail restored.
REQ-040 A bench SHALL check: flush at count=9 with retire_cnt=2 -> next cycle empty=1, all checkpoints free.
